rhs_cmd_sequencer: RTL and testbench

- Command scheduler in front of rhs_spi_master for one RHS2116 headstage.
- After enable, plays a host-loaded register-init list, then runs CONVERT scans of all channels, one scan per frame_tick.
- Uses the RHS two-command result pipeline to tag each returned word with its channel.
- Emits a channel-tagged sample stream toward the packetizer.

---
 rtl/rhs_pkg.sv | 24 ++
 rtl/rhs_cmd_sequencer_if.sv | 24 ++
 rtl/rhs_cmd_ram.sv | 24 ++
 rtl/rhs_cmd_sequencer.sv | 170 +++++++++++++++++
 tb/tb_rhs_cmd_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rhs_pkg.sv
// Shared types and command encodings for the RHS2116 command sequencer.
package rhs_pkg;

  localparam int unsigned N_CH_MAX = 32;

  // READ of register 255: harmless filler that flushes the result pipeline
  localparam logic [31:0] DUMMY = 32'hFFFF_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_RD,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_SCAN_IDLE,
    ST_SCAN_ISSUE,
    ST_SCAN_WAIT
  } state_t;

  // CONVERT command for one channel
  function automatic logic [31:0] convert(input logic [5:0] ch);
    return {10'b0, ch, 16'h0000};
  endfunction

endpackage

// File: rtl/rhs_cmd_sequencer_if.sv
// SPI-master command/result handshake plus the tagged sample stream.
interface rhs_cmd_sequencer_if #(
  parameter int unsigned CMD_W = 32
) ();

  logic             spi_start;
  logic [CMD_W-1:0] spi_cmd;
  logic             spi_done;
  logic [CMD_W-1:0] spi_rdata;
  logic             smp_valid;
  logic [5:0]       smp_chan;
  logic [CMD_W-1:0] smp_data;

  modport master (
    output spi_start, spi_cmd, smp_valid, smp_chan, smp_data,
    input  spi_done, spi_rdata
  );

  modport slave (
    input  spi_start, spi_cmd, smp_valid, smp_chan, smp_data,
    output spi_done, spi_rdata
  );

endinterface

// File: rtl/rhs_cmd_ram.sv
// Init command store: one write port, one registered read port.
module rhs_cmd_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write on strobe; read data appears one cycle after the address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/rhs_cmd_sequencer.sv
// Plays the init list, then one CONVERT scan per frame_tick, tagging results
// with the channel that produced them (results lag their command by two).
module rhs_cmd_sequencer
  import rhs_pkg::*;
#(
  parameter int unsigned N_CH       = 16,
  parameter int unsigned INIT_DEPTH = 32,
  parameter int unsigned CMD_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          frame_tick,
  input  logic [5:0]                    init_len,
  input  logic                          cfg_we,
  input  logic [$clog2(INIT_DEPTH)-1:0] cfg_addr,
  input  logic [CMD_W-1:0]              cfg_wdata,
  rhs_cmd_sequencer_if.master           bus,
  output logic                          init_done,
  output logic                          busy,
  output logic                          overrun,
  output logic                          cfg_err
);

  localparam int unsigned AW     = $clog2(INIT_DEPTH);
  localparam logic [5:0]  K_CONV = 6'(N_CH);
  localparam logic [5:0]  K_LAST = 6'(N_CH + 1);

  if (N_CH < 1 || N_CH > N_CH_MAX) begin : g_bad_n_ch
    $error("N_CH out of range");
  end

  state_t           state;
  logic [5:0]       idx;
  logic [5:0]       len_q;
  logic [5:0]       k;
  logic             ram_we;
  logic [CMD_W-1:0] ram_rdata;

  // Host writes land only while the sequencer is parked
  assign ram_we = cfg_we && (state == ST_IDLE);

  rhs_cmd_ram #(
    .DEPTH(INIT_DEPTH),
    .W    (CMD_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr(idx[AW-1:0]),
    .rdata(ram_rdata)
  );

  // Sequencer FSM with registered handshake, sample and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      len_q         <= '0;
      k             <= '0;
      bus.spi_start <= 1'b0;
      bus.spi_cmd   <= '0;
      bus.smp_valid <= 1'b0;
      bus.smp_chan  <= '0;
      bus.smp_data  <= '0;
      init_done     <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      bus.spi_start <= 1'b0;
      bus.smp_valid <= 1'b0;
      overrun       <= frame_tick && (state == ST_SCAN_ISSUE || state == ST_SCAN_WAIT);
      cfg_err       <= cfg_we && (state != ST_IDLE);

      case (state)
        ST_IDLE: begin
          if (enable) begin
            if (!init_done && init_len != 6'd0) begin
              state <= ST_INIT_RD;
              idx   <= '0;
              len_q <= init_len;
              busy  <= 1'b1;
            end else begin
              state     <= ST_SCAN_IDLE;
              init_done <= 1'b1;
            end
          end
        end

        // RAM read latency slot; nothing outstanding yet, so stopping is safe
        ST_INIT_RD: begin
          if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_INIT_ISSUE;
          end
        end

        ST_INIT_ISSUE: begin
          bus.spi_cmd   <= ram_rdata;
          bus.spi_start <= 1'b1;
          state         <= ST_INIT_WAIT;
        end

        // Init results carry nothing useful and are dropped
        ST_INIT_WAIT: begin
          if (bus.spi_done) begin
            idx <= idx + 6'd1;
            if (idx == len_q - 6'd1) begin
              init_done <= 1'b1;
              state     <= enable ? ST_SCAN_IDLE : ST_IDLE;
              busy      <= 1'b0;
            end else if (!enable) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_INIT_RD;
            end
          end
        end

        ST_SCAN_IDLE: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (frame_tick) begin
            k     <= '0;
            state <= ST_SCAN_ISSUE;
            busy  <= 1'b1;
          end
        end

        ST_SCAN_ISSUE: begin
          bus.spi_cmd   <= (k < K_CONV) ? CMD_W'(convert(k)) : CMD_W'(DUMMY);
          bus.spi_start <= 1'b1;
          state         <= ST_SCAN_WAIT;
        end

        // Word returned now belongs to the command issued two slots earlier
        ST_SCAN_WAIT: begin
          if (bus.spi_done) begin
            if (k >= 6'd2) begin
              bus.smp_valid <= 1'b1;
              bus.smp_chan  <= k - 6'd2;
              bus.smp_data  <= bus.spi_rdata;
            end
            if (k == K_LAST) begin
              state <= enable ? ST_SCAN_IDLE : ST_IDLE;
              busy  <= 1'b0;
            end else if (!enable) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              k     <= k + 6'd1;
              state <= ST_SCAN_ISSUE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rhs_cmd_sequencer.sv
// Self-checking bench: randomized-latency SPI slave, sample monitor and
// a frame-level reference model.
module tb_rhs_cmd_sequencer;

  localparam int NCH = 16;
  localparam int FRAME_TXN = NCH + 2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        frame_tick;
  logic [5:0]  init_len;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        init_done;
  logic        busy;
  logic        overrun;
  logic        cfg_err;

  rhs_cmd_sequencer_if #(.CMD_W(32)) bus ();

  rhs_cmd_sequencer #(
    .N_CH(NCH), .INIT_DEPTH(32), .CMD_W(32)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .init_len(init_len), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .bus(bus), .init_done(init_done),
    .busy(busy), .overrun(overrun), .cfg_err(cfg_err)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] cmd_q[$];
  logic [5:0]  chan_q[$];
  logic [31:0] data_q[$];
  int txn, ovr_cnt, cerr_cnt, proto_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected command of transaction t within a frame
  function automatic logic [31:0] model_cmd(input int t);
    return (t < NCH) ? (32'(t) << 16) : 32'hFFFF_0000;
  endfunction

  // Slave returns 0x1000 + txn; channel ch's result arrives in txn ch+2
  function automatic logic [31:0] model_data(input int ch);
    return 32'h1000 + 32'(ch + 2);
  endfunction

  // Behavioural SPI slave with random turnaround
  initial begin
    int dly;
    bit pend;
    bus.spi_done  = 1'b0;
    bus.spi_rdata = '0;
    pend = 1'b0;
    dly  = 0;
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (dly == 0) begin
            bus.spi_done  = 1'b1;
            bus.spi_rdata = 32'h1000 + 32'(txn);
            txn++;
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
        if (bus.spi_start) begin
          if (pend) proto_err++;
          cmd_q.push_back(bus.spi_cmd);
          pend = 1'b1;
          dly  = int'($urandom_range(0, 3));
        end
      end
    end
  end

  // Output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.smp_valid) begin
        chan_q.push_back(bus.smp_chan);
        data_q.push_back(bus.smp_data);
      end
      if (overrun) ovr_cnt++;
      if (cfg_err) cerr_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    cmd_q.delete();
    chan_q.delete();
    data_q.delete();
    txn = 0;
    ovr_cnt = 0;
    cerr_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0; init_len = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_cmds(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cmd_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_init_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0;
    init_len = '0; cfg_addr = '0; cfg_wdata = '0;
    cyc(3);
    checks++;
    if ({bus.spi_start, bus.smp_valid, init_done, busy, overrun, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.spi_start, bus.smp_valid, init_done, busy, overrun, cfg_err});
    end
    checks++;
    if (bus.spi_cmd !== 32'h0) begin
      errors++; $display("FAIL reset_spi_cmd: got %h expected 0", bus.spi_cmd);
    end
    checks++;
    if ({bus.smp_chan, bus.smp_data} !== 38'h0) begin
      errors++; $display("FAIL reset_smp: got %h/%h expected 0", bus.smp_chan, bus.smp_data);
    end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_init();
    logic [31:0] exp3 [3];
    bit ok;
    exp3[0] = 32'h80AA_0001; exp3[1] = 32'h80AB_0002; exp3[2] = 32'h80AC_0003;
    clear_logs();
    for (int a = 0; a < 32; a++) begin
      cfg_addr  = 5'(a);
      cfg_wdata = (a < 3) ? exp3[a] : $urandom;
      cfg_we    = 1'b1;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    init_len = 6'd3;
    enable = 1'b1;
    wait_init_done(300, ok);
    checks++;
    if (!ok || txn != 3 || cmd_q.size() != 3) begin
      errors++;
      $display("FAIL init_done_timing: got done=%0d txn=%0d cmds=%0d expected 1/3/3",
               ok, txn, cmd_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] got;
      got = (i < cmd_q.size()) ? cmd_q[i] : 32'hDEAD_BEEF;
      checks++;
      if (got !== exp3[i]) begin
        errors++; $display("FAIL init_cmd[%0d]: got %h expected %h", i, got, exp3[i]);
      end
    end
    cyc(2);
    checks++;
    if (chan_q.size() != 0 || busy !== 1'b0 || cerr_cnt != 0) begin
      errors++;
      $display("FAIL init_quiet: got samples=%0d busy=%b cfg_err=%0d expected 0/0/0",
               chan_q.size(), busy, cerr_cnt);
    end
  endtask

  task automatic test_scan_frame();
    bit ok;
    for (int f = 0; f < 3; f++) begin
      clear_logs();
      pulse_tick();
      wait_idle(600, ok);
      checks++;
      if (!ok || cmd_q.size() != FRAME_TXN) begin
        errors++;
        $display("FAIL frame%0d_len: got done=%0d txns=%0d expected 1/%0d",
                 f, ok, cmd_q.size(), FRAME_TXN);
      end
      for (int t = 0; t < cmd_q.size() && t < FRAME_TXN; t++) begin
        checks++;
        if (cmd_q[t] !== model_cmd(t)) begin
          errors++; $display("FAIL frame%0d_cmd[%0d]: got %h expected %h", f, t, cmd_q[t], model_cmd(t));
        end
      end
      checks++;
      if (chan_q.size() != NCH || ovr_cnt != 0) begin
        errors++;
        $display("FAIL frame%0d_samples: got n=%0d ovr=%0d expected %0d/0", f, chan_q.size(), ovr_cnt, NCH);
      end
      for (int c = 0; c < chan_q.size() && c < NCH; c++) begin
        checks++;
        if (chan_q[c] !== 6'(c) || data_q[c] !== model_data(c)) begin
          errors++;
          $display("FAIL frame%0d_smp[%0d]: got chan=%0d data=%h expected chan=%0d data=%h",
                   f, c, chan_q[c], data_q[c], c, model_data(c));
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    for (int it = 0; it < 2; it++) begin
      int at;
      at = (it == 0) ? 5 : int'($urandom_range(3, 15));
      clear_logs();
      pulse_tick();
      wait_cmds(at, 300, ok);
      pulse_tick();
      wait_idle(600, ok);
      checks++;
      if (!ok || ovr_cnt != 1 || cmd_q.size() != FRAME_TXN || chan_q.size() != NCH) begin
        errors++;
        $display("FAIL overrun%0d: got ovr=%0d txns=%0d samples=%0d expected 1/%0d/%0d",
                 it, ovr_cnt, cmd_q.size(), chan_q.size(), FRAME_TXN, NCH);
      end
      clear_logs();
      cyc(2);
      pulse_tick();
      wait_idle(600, ok);
      checks++;
      if (!ok || cmd_q.size() != FRAME_TXN || cmd_q[0] !== model_cmd(0) ||
          chan_q.size() != NCH || ovr_cnt != 0) begin
        errors++;
        $display("FAIL overrun%0d_next_frame: got txns=%0d first=%h samples=%0d ovr=%0d expected %0d/%h/%0d/0",
                 it, cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 32'hx, chan_q.size(), ovr_cnt,
                 FRAME_TXN, model_cmd(0), NCH);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    clear_logs();
    pulse_tick();
    wait_cmds(7, 300, ok);
    enable = 1'b0;
    wait_idle(300, ok);
    cyc(1);
    checks++;
    if (!ok || cmd_q.size() != 7 || chan_q.size() != 5 || busy !== 1'b0 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL drop_counts: got txns=%0d samples=%0d busy=%b init_done=%b expected 7/5/0/1",
               cmd_q.size(), chan_q.size(), busy, init_done);
    end
    for (int c = 0; c < chan_q.size() && c < 5; c++) begin
      checks++;
      if (chan_q[c] !== 6'(c) || data_q[c] !== model_data(c)) begin
        errors++;
        $display("FAIL drop_smp[%0d]: got chan=%0d data=%h expected chan=%0d data=%h",
                 c, chan_q[c], data_q[c], c, model_data(c));
      end
    end
    pulse_tick();
    cyc(6);
    checks++;
    if (cmd_q.size() != 7 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle_tick: got txns=%0d busy=%b expected 7/0", cmd_q.size(), busy);
    end
    clear_logs();
    enable = 1'b1;
    cyc(2);
    pulse_tick();
    wait_idle(600, ok);
    checks++;
    if (!ok || cmd_q.size() != FRAME_TXN || cmd_q[0] !== model_cmd(0) || chan_q.size() != NCH) begin
      errors++;
      $display("FAIL drop_resume: got txns=%0d first=%h samples=%0d expected %0d/%h/%0d",
               cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 32'hx, chan_q.size(),
               FRAME_TXN, model_cmd(0), NCH);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    clear_logs();
    pulse_tick();
    wait_cmds(3, 300, ok);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.spi_start, bus.smp_valid, init_done, busy, overrun, cfg_err} !== 6'b0 ||
        bus.spi_cmd !== 32'h0 || bus.smp_data !== 32'h0 || bus.smp_chan !== 6'h0) begin
      errors++;
      $display("FAIL rst_mid: got flags=%b cmd=%h chan=%0d data=%h expected all zero",
               {bus.spi_start, bus.smp_valid, init_done, busy, overrun, cfg_err},
               bus.spi_cmd, bus.smp_chan, bus.smp_data);
    end
    cyc(2);
    rst = 1'b0;
    cyc(5);
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b0) begin
      errors++; $display("FAIL rst_after: got busy=%b init_done=%b expected 0/0", busy, init_done);
    end
  endtask

  task automatic test_init_len0();
    bit ok;
    do_reset();
    clear_logs();
    init_len = 6'd0;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_done: got init_done=%b busy=%b expected 1/0", init_done, busy);
    end
    cyc(1);
    pulse_tick();
    wait_idle(600, ok);
    checks++;
    if (!ok || cmd_q.size() != FRAME_TXN || cmd_q[0] !== 32'h0000_0000 || chan_q.size() != NCH) begin
      errors++;
      $display("FAIL len0_frame: got txns=%0d first=%h samples=%0d expected %0d/00000000/%0d",
               cmd_q.size(), (cmd_q.size() > 0) ? cmd_q[0] : 32'hx, chan_q.size(), FRAME_TXN, NCH);
    end
    enable = 1'b0;
    cyc(2);
  endtask

  task automatic test_cfg_err();
    logic [31:0] orig [4];
    bit ok;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      orig[a]   = $urandom;
      cfg_addr  = 5'(a);
      cfg_wdata = orig[a];
      cfg_we    = 1'b1;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      clear_logs();
      init_len = 6'd4;
      enable = 1'b1;
      if (pass == 0) begin
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        cfg_addr  = 5'd1;
        cfg_wdata = ~orig[1];
        cfg_we    = 1'b1;
        @(negedge clk);
        cfg_we    = 1'b0;
      end
      wait_init_done(400, ok);
      cyc(2);
      checks++;
      if (!ok || cmd_q.size() != 4 || cerr_cnt != ((pass == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL cfg_err_pass%0d: got done=%0d txns=%0d cfg_err=%0d expected 1/4/%0d",
                 pass, ok, cmd_q.size(), cerr_cnt, (pass == 0) ? 1 : 0);
      end
      for (int i = 0; i < cmd_q.size() && i < 4; i++) begin
        checks++;
        if (cmd_q[i] !== orig[i]) begin
          errors++; $display("FAIL cfg_ram_pass%0d[%0d]: got %h expected %h", pass, i, cmd_q[i], orig[i]);
        end
      end
      do_reset();
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err != 0) begin
      errors++; $display("FAIL overlap_start: got %0d expected 0", proto_err);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0;
    init_len = '0; cfg_addr = '0; cfg_wdata = '0;
    txn = 0; ovr_cnt = 0; cerr_cnt = 0; proto_err = 0;
    test_reset();
    test_init();
    test_scan_frame();
    test_overrun();
    test_enable_drop();
    test_rst_mid();
    test_init_len0();
    test_cfg_err();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
